// File: rtl/tri_line_pkg.sv
`default_nettype none
// ============================================================================
// tri_line_pkg : state encoding and synchronizer depth for tri_line_rx
// Rev 1.0 : initial release
// ============================================================================
package tri_line_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/tri_line_sync.sv
`default_nettype none
// ============================================================================
// tri_line_sync : multi-flop synchronizer, resets to the idle-high line level
// Rev 1.0 : initial release
// ============================================================================
module tri_line_sync
  import tri_line_pkg::*;
#(
  parameter int DEPTH = SYNC_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/tri_line_rx.sv
`default_nettype none
// ============================================================================
// tri_line_rx : async serial receiver on a shared pulled-up line, with a
// valid/ready holding register. Optional even parity: TRI_LINE_PARITY_EN.
// Rev 1.0 : initial release
// ============================================================================
module tri_line_rx
  import tri_line_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
`ifdef TRI_LINE_PARITY_EN
  output logic              parity_err,
`endif
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam int SW = $clog2(SYNC_DEPTH + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [SW-1:0] SETTLED  = SW'(SYNC_DEPTH);

  logic              line_s;
  state_t            state_q,     state_d;
  logic [CW-1:0]     cnt_q,       cnt_d;
  logic [BW-1:0]     bit_q,       bit_d;
  logic [DATA_W-1:0] shift_q,     shift_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic              valid_q,     valid_d;
  logic              ferr_q,      ferr_d;
  logic              ovr_q,       ovr_d;
  logic [SW-1:0]     settle_q,    settle_d;
  logic              line_prev_q, line_prev_d;
  logic              word_done;
`ifdef TRI_LINE_PARITY_EN
  logic              par_q,       par_d;
  logic              perr_q,      perr_d;
`endif

  tri_line_sync #(
    .DEPTH (SYNC_DEPTH)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (line),
    .q     (line_s)
  );

  // The synchronizer comes out of reset holding 1s, not the real line level;
  // edge history is held low until real samples arrive so a line that was
  // already low at release cannot look like a fresh start edge.
  always_comb begin
    settle_d    = (settle_q == SETTLED) ? settle_q : settle_q + 1'b1;
    line_prev_d = (settle_q == SETTLED) ? line_s : 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    word_done = 1'b0;
`ifdef TRI_LINE_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (line_prev_q && !line_s) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = line_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {line_s, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef TRI_LINE_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef TRI_LINE_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = line_s;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          ferr_d  = !line_s;
`ifdef TRI_LINE_PARITY_EN
          perr_d    = ^{shift_q, par_q};
          word_done = line_s && !perr_d;
`else
          word_done = line_s;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A completing word may take the slot being freed by this cycle's handshake.
    if (word_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      settle_q    <= '0;
      line_prev_q <= 1'b0;
`ifdef TRI_LINE_PARITY_EN
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      settle_q    <= settle_d;
      line_prev_q <= line_prev_d;
`ifdef TRI_LINE_PARITY_EN
      par_q       <= par_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef TRI_LINE_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
`default_nettype wire
